// File: rtl/light_display_if.sv
// Sensor-to-display link: the 8-bit light sample handshake plus the 7-segment drive lines.
// master = sample producer / board pins side, slave = light_display.
interface light_display_if;
    logic [7:0] sample;
    logic       sample_valid;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    modport master (
        output sample, sample_valid,
        input  busy, seg, an, dp
    );

    modport slave (
        input  sample, sample_valid,
        output busy, seg, an, dp
    );
endinterface

// File: rtl/light_display.sv
// Light sample -> 3-digit decimal (sequential double-dabble) -> multiplexed 4-digit 7-segment scan.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero hundreds/tens digits.
module light_display #(
    parameter int REFRESH_COUNT = 10000
) (
    input  logic             clk,
    input  logic             reset,
    light_display_if.slave   bus
);
    localparam int CNT_W = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  shift_cnt_reg;
    logic [7:0]  bin_reg;
    logic [11:0] bcd_reg;
    logic [11:0] bcd_adj;
    logic [19:0] shifted;
    logic [11:0] digits_reg;   // {hundreds, tens, ones}, only written at COMMIT

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.sample_valid) state_next = SHIFT;
            SHIFT:   if (shift_cnt_reg == 3'd7) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state_reg != IDLE);

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_add3
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    assign shifted = {bcd_adj, bin_reg} << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_reg       <= '0;
            bcd_reg       <= '0;
            shift_cnt_reg <= '0;
            digits_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.sample_valid) begin
                        bin_reg       <= bus.sample;
                        bcd_reg       <= '0;
                        shift_cnt_reg <= '0;
                    end
                end
                SHIFT: begin
                    {bcd_reg, bin_reg} <= shifted;
                    shift_cnt_reg      <= shift_cnt_reg + 3'd1;
                end
                COMMIT:  digits_reg <= bcd_reg;
                default: ;
            endcase
        end
    end

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    logic [CNT_W-1:0] refresh_cnt_reg;
    logic [1:0]       sel_reg;
    logic [3:0]       an_reg, an_next;
    logic [6:0]       seg_reg, seg_next;
    logic [3:0]       slot_digit;
    logic             slot_blank;
    logic             wrap;

    assign wrap = (refresh_cnt_reg == CNT_LAST);

    always_comb begin
        slot_digit = 4'd0;
        slot_blank = 1'b0;
        case (sel_reg)
            2'd0:    slot_digit = digits_reg[3:0];
            2'd1:    slot_digit = digits_reg[7:4];
            2'd2:    slot_digit = digits_reg[11:8];
            default: slot_blank = 1'b1;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (sel_reg == 2'd2 && digits_reg[11:8] == 4'd0) slot_blank = 1'b1;
        if (sel_reg == 2'd1 && digits_reg[11:4] == 8'd0) slot_blank = 1'b1;
`endif
        an_next  = ~(4'b0001 << sel_reg);
        seg_next = slot_blank ? 7'b1111111 : seg_decode(slot_digit);
    end

    // Slot shown at a wrap is the one selected before the wrap, so ones appears first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            refresh_cnt_reg <= '0;
            sel_reg         <= 2'd0;
            an_reg          <= 4'b1111;
            seg_reg         <= 7'b1111111;
        end else if (wrap) begin
            refresh_cnt_reg <= '0;
            sel_reg         <= sel_reg + 2'd1;
            an_reg          <= an_next;
            seg_reg         <= seg_next;
        end else begin
            refresh_cnt_reg <= refresh_cnt_reg + 1'b1;
        end
    end

    assign bus.an  = an_reg;
    assign bus.seg = seg_reg;
    assign bus.dp  = 1'b1;
endmodule
